// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types, accumulator sizing and saturation bounds for fir_filter_n
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } fir_state_t;

    // Accumulator width: full-precision product plus headroom for NTAPS additions
    function automatic int acc_width(input int data_w, input int ntaps);
        return 2 * data_w + $clog2(ntaps);
    endfunction

    // Largest signed value representable in data_w bits
    function automatic longint sat_hi(input int data_w);
        return (longint'(1) <<< (data_w - 1)) - longint'(1);
    endfunction

    // Smallest signed value representable in data_w bits
    function automatic longint sat_lo(input int data_w);
        return -(longint'(1) <<< (data_w - 1));
    endfunction

endpackage

// File: rtl/fir_block_counter.sv
// rtl/fir_block_counter.sv - modulo-BLOCK_SIZE output counter with wrap pulse
module fir_block_counter #(
    parameter int BLOCK_SIZE = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic incr,
    output logic wrap
);

    localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_SIZE - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == LAST);
    // The increment that returns the count to zero is the block boundary
    assign wrap    = incr && at_last;

    // Count outputs; a clear restarts the block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (incr) begin
            cnt <= at_last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_filter_n.sv
// rtl/fir_filter_n.sv - N-tap sequential-MAC FIR filter with saturation and magnitude output
module fir_filter_n
    import fir_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NTAPS      = 4,
    parameter int BLOCK_SIZE = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] coeff_data,
    input  logic              coeff_valid,
    output logic              coeff_ready,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              mag_mode,
    output logic [DATA_W-1:0] fir_out,
    output logic              out_valid,
    output logic              modwait,
    output logic              one_k_samples,
    output logic              err
);

    localparam int ACC_W = acc_width(DATA_W, NTAPS);
    localparam int IDX_W = $clog2(NTAPS);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0]  SAT_HI   = ACC_W'(sat_hi(DATA_W));
    localparam logic signed [ACC_W-1:0]  SAT_LO   = ACC_W'(sat_lo(DATA_W));
    localparam logic signed [DATA_W-1:0] OUT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] OUT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    fir_state_t state, state_nxt;

    logic signed [DATA_W-1:0]   coeff [NTAPS];
    logic signed [DATA_W-1:0]   d     [NTAPS];
    logic signed [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]           idx;
    logic                       coeff_loaded;
    logic                       mag_q;
    logic [DATA_W-1:0]          fir_out_q;
    logic                       err_q;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    r;
    logic signed [DATA_W-1:0]   r_sat;
    logic signed [DATA_W-1:0]   result;
    logic                       sat_hit;
    logic                       load_start;
    logic                       sample_take;

    assign coeff_ready   = (state == LOAD);
    // A pending coefficient load wins over a sample offered in the same cycle
    assign sample_ready  = (state == IDLE) && coeff_loaded && !coeff_valid;
    assign modwait       = (state != IDLE);
    assign out_valid     = (state == OUT);
    assign load_start    = (state == IDLE) && coeff_valid;
    assign sample_take   = sample_ready && sample_valid;
    assign fir_out       = (state == OUT) ? result : fir_out_q;
    assign err           = err_q | ((state == OUT) && sat_hit);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (coeff_valid) begin
                    state_nxt = LOAD;
                end else if (coeff_loaded && sample_valid) begin
                    state_nxt = MAC;
                end
            end
            LOAD: if (coeff_valid && idx == LAST_IDX) state_nxt = IDLE;
            MAC:  if (idx == LAST_IDX) state_nxt = OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tap product, rescale from Q2.(2*DATA_W-2) to Q1.(DATA_W-1), clamp, optional magnitude
    always_comb begin
        prod    = (2*DATA_W)'(coeff[idx]) * (2*DATA_W)'(d[idx]);
        r       = acc >>> (DATA_W - 1);
        sat_hit = 1'b0;
        if (r > SAT_HI) begin
            r_sat   = OUT_MAX;
            sat_hit = 1'b1;
        end else if (r < SAT_LO) begin
            r_sat   = OUT_MIN;
            sat_hit = 1'b1;
        end else begin
            r_sat   = r[DATA_W-1:0];
        end
        result = r_sat;
        if (mag_q && r_sat[DATA_W-1]) begin
            result = (r_sat == OUT_MIN) ? OUT_MAX : -r_sat;
        end
    end

    // Coefficient loading, delay line, accumulation and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) begin
                coeff[k] <= '0;
                d[k]     <= '0;
            end
            acc          <= '0;
            idx          <= '0;
            coeff_loaded <= 1'b0;
            mag_q        <= 1'b0;
            fir_out_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_start) begin
                        for (int k = 0; k < NTAPS; k++) d[k] <= '0;
                        err_q        <= 1'b0;
                        coeff_loaded <= 1'b0;
                        idx          <= '0;
                    end else if (sample_take) begin
                        for (int k = NTAPS - 1; k > 0; k--) d[k] <= d[k-1];
                        d[0]  <= sample_data;
                        mag_q <= mag_mode;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (coeff_valid) begin
                        coeff[idx] <= coeff_data;
                        if (idx == LAST_IDX) begin
                            coeff_loaded <= 1'b1;
                            idx          <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                OUT: begin
                    fir_out_q <= result;
                    if (sat_hit) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    fir_block_counter #(
        .BLOCK_SIZE(BLOCK_SIZE)
    ) u_block_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(load_start),
        .incr (state == OUT),
        .wrap (one_k_samples)
    );

endmodule

// File: tb/tb_fir_filter_n.sv
// tb/tb_fir_filter_n.sv - directed self-checking bench for fir_filter_n
module tb_fir_filter_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] coeff_data = '0;
    logic        coeff_valid = 1'b0;
    logic        coeff_ready;
    logic [15:0] sample_data = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        mag_mode = 1'b0;
    logic [15:0] fir_out;
    logic        out_valid;
    logic        modwait;
    logic        one_k_samples;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    fir_filter_n #(
        .DATA_W(16),
        .NTAPS(4),
        .BLOCK_SIZE(1000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coeff_data   (coeff_data),
        .coeff_valid  (coeff_valid),
        .coeff_ready  (coeff_ready),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mag_mode     (mag_mode),
        .fir_out      (fir_out),
        .out_valid    (out_valid),
        .modwait      (modwait),
        .one_k_samples(one_k_samples),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_load(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3,
                           input logic also_sample, output int cycles);
        logic [15:0] c [4];
        int   idx;
        logic rdy;
        c = '{c0, c1, c2, c3};
        idx = 0;
        cycles = 0;
        @(negedge clk);
        coeff_valid = 1'b1;
        coeff_data  = c[0];
        if (also_sample) begin
            sample_valid = 1'b1;
            sample_data  = 16'h1234;
            #1;
            n_cmp++;
            if (sample_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL priority_sample_ready: got %b required 0", sample_ready);
            end
        end
        while (idx < 4 && cycles < 20) begin
            rdy = coeff_ready;
            @(posedge clk);
            cycles++;
            if (rdy) idx++;
            #1;
            sample_valid = 1'b0;
            if (idx < 4) coeff_data = c[idx];
            else coeff_valid = 1'b0;
        end
        coeff_valid = 1'b0;
        if (idx < 4) begin
            n_cmp++;
            n_bad++;
            $display("FAIL load_timeout: accepted %0d words required 4", idx);
        end
    endtask

    task automatic do_sample(input logic [15:0] s, input logic mode,
                             output logic [15:0] res, output logic e,
                             output logic onek, output int lat);
        int w;
        res  = '0;
        e    = 1'b0;
        onek = 1'b0;
        lat  = 0;
        @(negedge clk);
        sample_data  = s;
        mag_mode     = mode;
        sample_valid = 1'b1;
        w = 0;
        while (!sample_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!sample_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: sample_ready=%b required 1", sample_ready);
            sample_valid = 1'b0;
            lat = 99;
            return;
        end
        @(posedge clk);
        #1 sample_valid = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                res  = fir_out;
                e    = err;
                onek = one_k_samples;
                break;
            end
        end
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
            lat = 99;
        end
    endtask

    task automatic test_reset();
        logic [21:0] outs;
        repeat (2) @(negedge clk);
        outs = {fir_out, out_valid, one_k_samples, err, modwait, coeff_ready, sample_ready};
        n_cmp++;
        if (outs !== 22'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 000000", outs);
        end
        rst = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 16'h1000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({sample_ready, modwait} !== 2'b00) begin
            n_bad++;
            $display("FAIL no_coeff_sample_ready: got %b%b required 00", sample_ready, modwait);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_basic();
        int cyc, lat;
        logic [15:0] res;
        logic e, ok;
        do_load(16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, cyc);
        n_cmp++;
        if (cyc != 5 || modwait !== 1'b0) begin
            n_bad++;
            $display("FAIL load_cycles: got %0d modwait=%b required 5 modwait=0", cyc, modwait);
        end
        do_sample(16'h1000, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h0800) begin
            n_bad++;
            $display("FAIL basic_out: got %h required 0800", res);
        end
        n_cmp++;
        if (lat != 5) begin
            n_bad++;
            $display("FAIL basic_latency: got %0d required 5", lat);
        end
        n_cmp++;
        if (e !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_err: got %b required 0", e);
        end
    endtask

    task automatic test_taps();
        int cyc, lat;
        logic [15:0] res;
        logic e, ok;
        logic [15:0] smp [4];
        logic [15:0] exp_out [4];
        smp     = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
        exp_out = '{16'h1000, 16'h2000, 16'h3000, 16'h3FFF};
        do_load(16'h2000, 16'h4000, 16'h6000, 16'h7FFF, 1'b0, cyc);
        for (int i = 0; i < 4; i++) begin
            do_sample(smp[i], 1'b0, res, e, ok, lat);
            n_cmp++;
            if (res !== exp_out[i]) begin
                n_bad++;
                $display("FAIL taps_out%0d: got %h required %h", i, res, exp_out[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int cyc, lat;
        logic [15:0] res;
        logic e, ok;
        do_load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0, cyc);
        do_sample(16'h7FFF, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h7FFE || e !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_first: got %h err=%b required 7ffe err=0", res, e);
        end
        repeat (3) do_sample(16'h7FFF, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h7FFF || e !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_pos: got %h err=%b required 7fff err=1", res, e);
        end
        repeat (4) do_sample(16'h8000, 1'b1, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h7FFF) begin
            n_bad++;
            $display("FAIL sat_neg_mag: got %h required 7fff", res);
        end
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b required 1", err);
        end
        do_load(16'h8000, 16'h8000, 16'h0000, 16'h0000, 1'b0, cyc);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear_on_load: got %b required 0", err);
        end
    endtask

    task automatic test_mag_boundary();
        int cyc, lat;
        logic [15:0] res;
        logic e, ok;
        do_sample(16'h4000, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'hC000) begin
            n_bad++;
            $display("FAIL neg_half: got %h required c000", res);
        end
        do_sample(16'h4000, 1'b1, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h7FFF || e !== 1'b0) begin
            n_bad++;
            $display("FAIL mag_min_map: got %h err=%b required 7fff err=0", res, e);
        end
        do_sample(16'h4000, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h8000 || e !== 1'b0) begin
            n_bad++;
            $display("FAIL signed_min: got %h err=%b required 8000 err=0", res, e);
        end
        do_load(16'h0001, 16'h0000, 16'h0000, 16'h0000, 1'b0, cyc);
        do_sample(16'hFFFF, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL floor_neg: got %h required ffff", res);
        end
        do_sample(16'hFFFF, 1'b1, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h0001) begin
            n_bad++;
            $display("FAIL mag_small: got %h required 0001", res);
        end
    endtask

    task automatic test_priority();
        int cyc, lat;
        logic [15:0] res;
        logic e, ok;
        do_load(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b0, cyc);
        repeat (2) do_sample(16'h7FFF, 1'b0, res, e, ok, lat);
        do_load(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, cyc);
        n_cmp++;
        if (cyc != 5) begin
            n_bad++;
            $display("FAIL priority_load_cycles: got %0d required 5", cyc);
        end
        do_sample(16'h1000, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h0800) begin
            n_bad++;
            $display("FAIL delay_zeroed: got %h required 0800", res);
        end
    endtask

    task automatic test_block();
        int cyc, lat, pulses, pos1, pos2, bad_lat;
        logic [15:0] res;
        logic e, onek;
        pulses = 0;
        pos1 = 0;
        pos2 = 0;
        bad_lat = 0;
        do_load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, cyc);
        for (int i = 1; i <= 2000; i++) begin
            do_sample(16'h0000, 1'b0, res, e, onek, lat);
            if (lat != 5) bad_lat++;
            if (onek) begin
                pulses++;
                if (pulses == 1) pos1 = i;
                if (pulses == 2) pos2 = i;
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_bad++;
            $display("FAIL onek_count: got %0d required 2", pulses);
        end
        n_cmp++;
        if (pos1 != 1000 || pos2 != 2000) begin
            n_bad++;
            $display("FAIL onek_positions: got %0d,%0d required 1000,2000", pos1, pos2);
        end
        n_cmp++;
        if (bad_lat != 0) begin
            n_bad++;
            $display("FAIL block_latency: got %0d bad outputs required 0", bad_lat);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, lat, seen;
        logic [15:0] res;
        logic e, ok;
        logic [21:0] outs;
        do_load(16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, cyc);
        @(negedge clk);
        sample_data  = 16'h1000;
        sample_valid = 1'b1;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {fir_out, out_valid, one_k_samples, err, modwait, coeff_ready, sample_ready};
        n_cmp++;
        if (outs !== 22'h0) begin
            n_bad++;
            $display("FAIL midmac_reset_outputs: got %h required 000000", outs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sample_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || sample_ready) seen++;
        end
        sample_valid = 1'b0;
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL post_reset_idle: got %0d active cycles required 0", seen);
        end
        do_load(16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0, cyc);
        do_sample(16'h1000, 1'b0, res, e, ok, lat);
        n_cmp++;
        if (res !== 16'h0800) begin
            n_bad++;
            $display("FAIL after_reload: got %h required 0800", res);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_taps();
        test_saturation();
        test_mag_boundary();
        test_priority();
        test_reset_mid();
        test_block();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_filter_n.md
# fir_filter_n

Parametrised N-tap FIR filter: the next generation of the team's 4-point FIR, generalised in data width, tap count and output mode. It accepts coefficients and samples through valid/ready handshakes and runs one sequential multiply-accumulate per tap. It produces a saturated signed or magnitude result, a block-boundary pulse and a sticky overflow flag. It sits between the sample source (ADC or test interface) and the downstream output register/host.

## Interface
- DATA_W, 16, sample, coefficient and output width (8..24)
- NTAPS, 4, filter taps (2..16)
- BLOCK_SIZE, 1000, outputs per one_k_samples pulse
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- coeff_data  in  DATA_W  signed Q1.(DATA_W-1) coefficient
- coeff_valid  in  1  coeff_data valid
- coeff_ready  out  1  coefficient accepted when valid&&ready
- sample_data  in  DATA_W  signed Q1.(DATA_W-1) sample
- sample_valid  in  1  sample_data valid
- sample_ready  out  1  sample accepted when valid&&ready
- mag_mode  in  1  1 = output |result|, 0 = signed result; sampled on sample acceptance
- fir_out  out  DATA_W  filter result, held until the next result
- out_valid  out  1  one-cycle pulse, fir_out updated
- modwait  out  1  block busy (not IDLE)
- one_k_samples  out  1  one-cycle pulse on every BLOCK_SIZE-th output
- err  out  1  sticky saturation flag

## Operation
- Storage: coeff[0..NTAPS-1] and delay line d[0..NTAPS-1]; d[0] is the newest sample.
- States: IDLE, LOAD, MAC, OUT.
- IDLE, coeff_valid=1 -> LOAD. Coefficient loading has priority over sample_valid in the same cycle.
  - Load start: zero the delay line, clear err, clear the block counter, clear coeff_loaded.
  - The first word is written to coeff[0].
- LOAD: coeff_ready=1. Each handshake writes coeff[idx] and increments idx.
  - After coeff[NTAPS-1] is written: coeff_loaded=1, -> IDLE.
  - No timeout; modwait stays high while waiting between words.
- IDLE, coeff_loaded=1, sample_valid=1: sample_ready=1.
  - On acceptance: shift d (d[k]<=d[k-1], d[0]<=sample_data), latch mag_mode, clear acc, -> MAC.
- MAC: NTAPS cycles, tap k=0..NTAPS-1, acc += coeff[k]*d[k].
  - Products are signed 2*DATA_W bits.
  - acc is signed ACC_W = 2*DATA_W + clog2(NTAPS) bits and never wraps.
- OUT, one cycle:
  - r = acc >>> (DATA_W-1), arithmetic shift, floor.
  - If r > 2^(DATA_W-1)-1 or r < -2^(DATA_W-1): saturate to the nearest bound and set err.
  - mag_mode=1: fir_out = |r_sat|, with -2^(DATA_W-1) mapped to 2^(DATA_W-1)-1. This mapping alone does not set err.
  - Assert out_valid, increment the block counter, -> IDLE.
- Block counter: counts 0..BLOCK_SIZE-1. The output that wraps it to 0 asserts one_k_samples together with out_valid.
- coeff_ready=0 outside LOAD. sample_ready=0 outside IDLE and while coeff_loaded=0.

## Timing
- Reset values (asynchronous): state IDLE, coefficients 0, delay line 0, acc 0, coeff_loaded 0, idx 0, counter 0.
  - Outputs: fir_out 0, out_valid 0, one_k_samples 0, err 0, modwait 0, coeff_ready 0, sample_ready 0.
- Sample accepted at edge 0. MAC occupies cycles 1..NTAPS. out_valid and one_k_samples are high in cycle NTAPS+1.
  - Latency is NTAPS+1 cycles; throughput is one sample per NTAPS+2 cycles.
- modwait: high from the cycle after acceptance through the OUT cycle, and throughout LOAD. Low in IDLE.
- Coefficient load: NTAPS handshakes, at most one per cycle. With coeff_valid held high, the block returns to IDLE NTAPS+1 cycles after the first valid.
- Reset asserted mid-MAC or mid-LOAD: all state is discarded immediately. No out_valid is produced, and the coefficients must be reloaded.
- sample_valid while busy: the sample is not accepted. It is the source's responsibility to hold it (no error is raised).

## Structure
- Package fir_pkg:
  - state enum fir_state_t (IDLE, LOAD, MAC, OUT)
  - function computing ACC_W from DATA_W and NTAPS
  - saturation-bound constants derived from DATA_W
- One sub-module: fir_block_counter (BLOCK_SIZE parameter, clear/incr inputs, wrap pulse output).
- The datapath and FSM live in fir_filter_n.

## Test plan
- Load coeffs {0x4000,0,0,0}, then sample 0x1000 -> out_valid exactly 5 cycles later, fir_out=0x0800, err=0.
- Load coeffs {0x2000,0x4000,0x6000,0x7FFF}, then samples 0x4000,0,0,0 -> outputs 0x1000, 0x2000, 0x3000, 0x3FFF.
- Saturation:
  - All coeffs 0x7FFF, four samples 0x7FFF -> 4th output 0x7FFF, err=1; err stays 1 until the next coefficient load.
  - Same coeffs, samples 0x8000 with mag_mode=1 -> 0x7FFF.
- Block counter: 2000 samples with BLOCK_SIZE=1000 -> one_k_samples pulses coincide with the 1000th and 2000th out_valid only.
- Priority: coeff_valid and sample_valid high together in IDLE -> coefficient accepted, sample_ready=0, delay line zeroed.
- Reset: assert rst in MAC cycle 2 -> no out_valid, all outputs at reset values, sample_ready=0 until coefficients are reloaded.
